// File: rtl/sbuf_uart.sv
// SBUF-style UART: TX/RX FIFOs, 8N1-style framing, sticky error flags.
// Define SBUF_PARITY_EN to add an even parity bit to every frame.
module sbuf_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic         drop
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push on full still lands.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

module sbuf_uart #(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_byte,
    input  logic              i_rd,
    input  logic              i_clr,
    input  logic              i_rxd,
    output logic              o_txd,
    output logic [DATA_W-1:0] o_sbuf,
    output logic              o_ri,
    output logic              o_ti,
    output logic              o_tx_busy,
    output logic              o_ovf,
    output logic              o_ferr,
    output logic              o_perr
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W);
    localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID     = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LAST    = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA,
`ifdef SBUF_PARITY_EN
        S_PAR,
`endif
        S_STOP
    } state_t;

    logic              tx_pop, tx_empty, tx_full, tx_drop;
    logic [DATA_W-1:0] tx_head;
    logic              rx_push, rx_empty, rx_drop, rx_full;

    sbuf_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(i_clk), .rst(i_rst), .push(i_wr), .din(i_byte), .pop(tx_pop),
        .dout(tx_head), .empty(tx_empty), .full(tx_full), .drop(tx_drop));

    state_t            tx_state, tx_nstate;
    logic [CW-1:0]     tx_cnt, tx_ncnt;
    logic [BW-1:0]     tx_bit, tx_nbit;
    logic [DATA_W-1:0] tx_shr, tx_nshr;
    logic              tx_end;

    assign tx_end = (tx_cnt == BIT_END);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shr   <= '0;
        end else begin
            tx_state <= tx_nstate;
            tx_cnt   <= tx_ncnt;
            tx_bit   <= tx_nbit;
            tx_shr   <= tx_nshr;
        end
    end

    always_comb begin
        tx_nstate = tx_state;
        tx_ncnt   = tx_cnt + 1'b1;
        tx_nbit   = tx_bit;
        tx_nshr   = tx_shr;
        tx_pop    = 1'b0;
        case (tx_state)
            S_IDLE: begin
                tx_ncnt = '0;
                if (!tx_empty) begin
                    tx_pop    = 1'b1;
                    tx_nshr   = tx_head;
                    tx_nstate = S_START;
                end
            end
            S_START: if (tx_end) begin
                tx_ncnt   = '0;
                tx_nbit   = '0;
                tx_nstate = S_DATA;
            end
            S_DATA: if (tx_end) begin
                tx_ncnt = '0;
                if (tx_bit == LAST)
`ifdef SBUF_PARITY_EN
                    tx_nstate = S_PAR;
`else
                    tx_nstate = S_STOP;
`endif
                else
                    tx_nbit = tx_bit + 1'b1;
            end
`ifdef SBUF_PARITY_EN
            S_PAR: if (tx_end) begin
                tx_ncnt   = '0;
                tx_nstate = S_STOP;
            end
`endif
            S_STOP: if (tx_end) begin
                tx_ncnt = '0;
                // Chain straight into the next start bit when more data waits.
                if (!tx_empty) begin
                    tx_pop    = 1'b1;
                    tx_nshr   = tx_head;
                    tx_nstate = S_START;
                end else begin
                    tx_nstate = S_IDLE;
                end
            end
            default: tx_nstate = S_IDLE;
        endcase
    end

    // Line level is registered from the current state, one cycle behind it.
    always_ff @(posedge i_clk) begin
        if (i_rst) o_txd <= 1'b1;
        else begin
            case (tx_state)
                S_START: o_txd <= 1'b0;
                S_DATA:  o_txd <= tx_shr[tx_bit];
`ifdef SBUF_PARITY_EN
                S_PAR:   o_txd <= ^tx_shr;
`endif
                default: o_txd <= 1'b1;
            endcase
        end
    end

    logic rx_meta, rx_s, rx_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_rxd;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    state_t            rx_state, rx_nstate;
    logic [CW-1:0]     rx_cnt, rx_ncnt;
    logic [BW-1:0]     rx_bit, rx_nbit;
    logic [DATA_W-1:0] rx_shr, rx_nshr;
    logic              rx_end, ferr_set;
`ifdef SBUF_PARITY_EN
    logic              rx_par, rx_npar, perr_set;
`endif

    assign rx_end = (rx_cnt == BIT_END);

    sbuf_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(i_clk), .rst(i_rst), .push(rx_push), .din(rx_shr), .pop(i_rd),
        .dout(o_sbuf), .empty(rx_empty), .full(rx_full), .drop(rx_drop));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shr   <= '0;
`ifdef SBUF_PARITY_EN
            rx_par   <= 1'b0;
`endif
        end else begin
            rx_state <= rx_nstate;
            rx_cnt   <= rx_ncnt;
            rx_bit   <= rx_nbit;
            rx_shr   <= rx_nshr;
`ifdef SBUF_PARITY_EN
            rx_par   <= rx_npar;
`endif
        end
    end

    always_comb begin
        rx_nstate = rx_state;
        rx_ncnt   = rx_cnt + 1'b1;
        rx_nbit   = rx_bit;
        rx_nshr   = rx_shr;
        rx_push   = 1'b0;
        ferr_set  = 1'b0;
`ifdef SBUF_PARITY_EN
        rx_npar   = rx_par;
        perr_set  = 1'b0;
`endif
        case (rx_state)
            S_IDLE: begin
                rx_ncnt = '0;
                if (rx_prev && !rx_s) rx_nstate = S_START;
            end
            S_START: if (rx_cnt == MID) begin
                rx_ncnt   = '0;
                rx_nbit   = '0;
                rx_nstate = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_end) begin
                rx_ncnt = '0;
                rx_nshr = {rx_s, rx_shr[DATA_W-1:1]};
                if (rx_bit == LAST)
`ifdef SBUF_PARITY_EN
                    rx_nstate = S_PAR;
`else
                    rx_nstate = S_STOP;
`endif
                else
                    rx_nbit = rx_bit + 1'b1;
            end
`ifdef SBUF_PARITY_EN
            S_PAR: if (rx_end) begin
                rx_ncnt   = '0;
                rx_npar   = rx_s;
                rx_nstate = S_STOP;
            end
`endif
            S_STOP: if (rx_end) begin
                rx_ncnt   = '0;
                rx_nstate = S_IDLE;
                if (!rx_s) ferr_set = 1'b1;
`ifdef SBUF_PARITY_EN
                else if ((^rx_shr) != rx_par) perr_set = 1'b1;
`endif
                else rx_push = 1'b1;
            end
            default: rx_nstate = S_IDLE;
        endcase
    end

    // Set events take priority over a same-cycle clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_ovf  <= 1'b0;
            o_ferr <= 1'b0;
        end else begin
            o_ovf  <= tx_drop | rx_drop | (o_ovf & ~i_clr);
            o_ferr <= ferr_set | (o_ferr & ~i_clr);
        end
    end

`ifdef SBUF_PARITY_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) o_perr <= 1'b0;
        else       o_perr <= perr_set | (o_perr & ~i_clr);
    end
`else
    assign o_perr = 1'b0;
`endif

    assign o_ri      = !rx_empty;
    assign o_ti      = !tx_full;
    assign o_tx_busy = (tx_state != S_IDLE) || !tx_empty;
endmodule
